// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: byte-parallel stream scanner. It takes a burst of bytes over a
// valid/ready handshake and feeds them MSB-first into a programmable pattern
// matcher. Each overlapping match raises a one-cycle match pulse, and a
// saturating counter tracks the matches of the current job.
module seq_scan_ctrl #(
   parameter int               PAT_W   = 8,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(8'b0101_0101),
   parameter int               CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             start,
   input  logic [7:0]       len,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);

   // seen counts 0..PAT_W, so it needs one more code point than PAT_W-1
   localparam int SEEN_W = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [PAT_W-1:0]  pattern_q, pattern_d;
   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [SEEN_W-1:0] seen_q, seen_d;
   logic [7:0]        remaining_q, remaining_d;
   logic [7:0]        byte_sr_q, byte_sr_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              match_q, match_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [PAT_W-1:0]  hist_next;
   logic              hit;

   // Match detect: history after this bit is shifted in, compared once full
   always_comb begin
      hist_next = {hist_q[PAT_W-2:0], byte_sr_q[bit_idx_q]};
      hit       = (seen_q >= SEEN_W'(PAT_W - 1)) && (hist_next == pattern_q);
   end

   // State register and datapath registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= IDLE;
         pattern_q   <= PAT_RST;
         hist_q      <= '0;
         seen_q      <= '0;
         remaining_q <= '0;
         byte_sr_q   <= '0;
         bit_idx_q   <= '0;
         match_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         hist_q      <= hist_d;
         seen_q      <= seen_d;
         remaining_q <= remaining_d;
         byte_sr_q   <= byte_sr_d;
         bit_idx_q   <= bit_idx_d;
         match_q     <= match_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state and output decode for the job sequencer
   always_comb begin
      // NOTE: every signal gets a default up front, so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      pattern_d   = pattern_q;
      hist_d      = hist_q;
      seen_d      = seen_q;
      remaining_d = remaining_q;
      byte_sr_d   = byte_sr_q;
      bit_idx_d   = bit_idx_q;
      match_d     = 1'b0;
      cnt_d       = cnt_q;
      in_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_we) begin
               pattern_d = cfg_pattern;
            end
            if (start) begin
               hist_d      = '0;
               seen_d      = '0;
               cnt_d       = '0;
               remaining_d = len;
               state_d     = (len != 8'd0) ? LOAD : DONE;
            end
         end

         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               byte_sr_d = in_data;
               bit_idx_d = 3'd7;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            busy = 1'b1;
            // An abort drops this cycle's bit, including any match it would raise
            if (abort) begin
               state_d = IDLE;
            end else begin
               hist_d = hist_next;
               if (seen_q != SEEN_W'(PAT_W)) begin
                  seen_d = seen_q + 1'b1;
               end
               if (hit) begin
                  match_d = 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               if (bit_idx_q == 3'd0) begin
                  remaining_d = remaining_q - 8'd1;
                  state_d     = (remaining_q == 8'd1) ? DONE : LOAD;
               end else begin
                  bit_idx_d = bit_idx_q - 3'd1;
               end
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed testbench for seq_scan_ctrl. Cycle 0 of each job is the cycle in
// which start is driven. Expected cycle numbers are worked out by hand from the
// job timing: byte j loads in cycle 1+9j, and bit i of that byte shifts in
// cycle 2+9j+i, so its match pulse appears in cycle 3+9j+i.
module tb_seq_scan_ctrl;

   localparam int PAT_W = 8;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic             start;
   logic [7:0]       len;
   logic             abort;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready, busy, done, match;
   logic [CNT_W-1:0] match_cnt;
   logic             s_in_ready, s_busy, s_done, s_match;
   logic [1:0]       s_match_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Per-job observations
   int         done_at, n_done, idle_at, n_ready, first_ready, n_match;
   int         mcyc [16];
   logic       end_match;
   logic [CNT_W-1:0] cnt_end;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .start(start), .len(len), .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done),
      .match(match), .match_cnt(match_cnt)
   );

   // Narrow-counter copy driven with the same stimulus, for saturation
   seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .start(start), .len(len), .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(s_in_ready), .busy(s_busy), .done(s_done),
      .match(s_match), .match_cnt(s_match_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [PAT_W-1:0] value);
      cfg_we      = 1'b1;
      cfg_pattern = value;
      tick();
      cfg_we      = 1'b0;
   endtask

   // Runs one job and records what the DUT did. Negative cycle/shift arguments
   // disable the optional event. cfg_at writes pattern 0x00 mid-job; restart_at
   // re-asserts start with len=0; rst_at pulses rst for one cycle.
   task automatic run_job(input logic [7:0] n, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int stall, input int abort_shift,
                          input int cfg_at, input int restart_at, input int rst_at);
      logic [7:0] data [3];
      int   k, shifts, stalled;
      logic rdy;
      data[0] = d0; data[1] = d1; data[2] = d2;
      done_at = -1; n_done = 0; idle_at = -1; n_ready = 0; first_ready = -1; n_match = 0;
      end_match = 1'b0; cnt_end = '0;
      k = 0; shifts = 0; stalled = 0;
      for (int i = 0; i < 16; i++) mcyc[i] = -1;
      for (int c = 0; c < 200; c++) begin
         if (c >= 1) begin
            if (done) begin
               n_done++;
               if (done_at < 0) done_at = c;
            end
            if (in_ready) begin
               n_ready++;
               if (first_ready < 0) first_ready = c;
            end
            if (match) begin
               if (n_match < 16) mcyc[n_match] = c;
               n_match++;
            end
            if (busy && !in_ready) shifts++;
            if (c >= 2 && !busy && !done) begin
               idle_at   = c;
               end_match = match;
               cnt_end   = match_cnt;
               break;
            end
         end
         rdy         = in_ready;
         start       = (c == 0) || (c == restart_at);
         len         = (c == 0) ? n : 8'd0;
         in_data     = data[(k < 3) ? k : 2];
         in_valid    = 1'b1;
         if (rdy && stalled < stall) begin
            in_valid = 1'b0;
            stalled++;
         end
         abort       = busy && !in_ready && (shifts == abort_shift);
         cfg_we      = (c == cfg_at);
         cfg_pattern = '0;
         rst         = (c == rst_at);
         tick();
         if (rdy && in_valid) k++;
      end
      start = 1'b0; abort = 1'b0; cfg_we = 1'b0; rst = 1'b0; in_valid = 1'b0; len = 8'd0;
      check("job_ends", 32'(idle_at >= 0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; start = 1'b0; len = 8'd0;
      abort = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      tick(); tick();
      rst = 1'b0;

      // Reset state, then idle
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_flags", {28'd0, in_ready, busy, done, match}, 32'd0);
      end
      check("idle_cnt", match_cnt, 32'd0);

      // Pattern 0xFF, stream FF 0F; the mid-job write of 0x00 must be ignored
      cfg_write(8'hFF);
      run_job(8'd2, 8'hFF, 8'h0F, 8'h00, 0, -1, 3, -1, -1);
      check("cfg_nmatch", n_match, 32'd1);
      check("cfg_mcyc",   mcyc[0], 32'd10);
      check("cfg_done",   done_at, 32'd19);
      check("cfg_cnt",    cnt_end, 32'd1);

      // rst during SHIFT (pattern still 0xFF, stream FF FF): matches at 10, 12
      run_job(8'd2, 8'hFF, 8'hFF, 8'h00, 0, -1, -1, -1, 12);
      check("rst_nmatch", n_match,   32'd2);
      check("rst_mcyc1",  mcyc[1],   32'd12);
      check("rst_idle",   idle_at,   32'd13);
      check("rst_match",  end_match, 32'd0);
      check("rst_cnt",    cnt_end,   32'd0);
      check("rst_ndone",  n_done,    32'd0);

      // Pattern back at reset value 0x55: one byte 0x55 matches on its last bit
      run_job(8'd1, 8'h55, 8'h00, 8'h00, 0, -1, -1, -1, -1);
      check("one_nready", n_ready,     32'd1);
      check("one_ready1", first_ready, 32'd1);
      check("one_done",   done_at,     32'd10);
      check("one_nmatch", n_match,     32'd1);
      check("one_mcyc",   mcyc[0],     32'd10);
      check("one_cnt",    cnt_end,     32'd1);

      // Two bytes 0x55: overlapping matches on bits 8, 10, 12, 14, 16
      run_job(8'd2, 8'h55, 8'h55, 8'h00, 0, -1, -1, -1, -1);
      check("two_nmatch", n_match, 32'd5);
      check("two_mcyc0",  mcyc[0], 32'd10);
      check("two_mcyc1",  mcyc[1], 32'd13);
      check("two_mcyc2",  mcyc[2], 32'd15);
      check("two_mcyc3",  mcyc[3], 32'd17);
      check("two_mcyc4",  mcyc[4], 32'd19);
      check("two_done",   done_at, 32'd19);
      check("two_ndone",  n_done,  32'd1);
      check("two_cnt",    cnt_end, 32'd5);

      // in_valid low for 3 LOAD cycles: in_ready held, everything 3 later
      run_job(8'd1, 8'h55, 8'h00, 8'h00, 3, -1, -1, -1, -1);
      check("stall_nready", n_ready, 32'd4);
      check("stall_done",   done_at, 32'd13);
      check("stall_mcyc",   mcyc[0], 32'd13);

      // Abort on the 4th SHIFT of byte 2 (bit 12): its match is dropped
      run_job(8'd2, 8'h55, 8'h55, 8'h00, 0, 12, -1, -1, -1);
      check("abort_idle",   idle_at,   32'd15);
      check("abort_ndone",  n_done,    32'd0);
      check("abort_nmatch", n_match,   32'd2);
      check("abort_mcyc1",  mcyc[1],   32'd13);
      check("abort_match",  end_match, 32'd0);
      check("abort_cnt",    cnt_end,   32'd2);
      tick(); tick(); tick();
      check("abort_hold",   match_cnt, 32'd2);

      // len=0 goes straight to DONE and clears the count
      run_job(8'd0, 8'h00, 8'h00, 8'h00, 0, -1, -1, -1, -1);
      check("len0_done",   done_at, 32'd1);
      check("len0_nready", n_ready, 32'd0);
      check("len0_cnt",    cnt_end, 32'd0);

      // start while busy is ignored
      run_job(8'd1, 8'h55, 8'h00, 8'h00, 0, -1, -1, 5, -1);
      check("busy_done",  done_at, 32'd10);
      check("busy_ndone", n_done,  32'd1);
      check("busy_cnt",   cnt_end, 32'd1);

      // Three bytes 0x55: nine matches; the 2-bit counter saturates at 3
      run_job(8'd3, 8'h55, 8'h55, 8'h55, 0, -1, -1, -1, -1);
      check("sat_done",   done_at,     32'd28);
      check("sat_nmatch", n_match,     32'd9);
      check("sat_cnt16",  cnt_end,     32'd9);
      check("sat_cnt2",   s_match_cnt, 32'd3);
      tick(); tick(); tick();
      check("sat_hold",   s_match_cnt, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Stream-scanning controller for the serial pattern-detection path. Accepts a burst of bytes over a valid/ready handshake and serializes each byte MSB-first into an internal programmable pattern matcher. It pulses on every overlapping match and keeps a saturating match count. It sequences one scan job at a time: start, length, done and abort. It replaces the hard-wired fixed-pattern detector where the pattern must be configurable and input arrives byte-parallel.

## Interface
- PAT_W, 8, pattern length in bits (legal 2..16)
- PAT_RST, 8'b0101_0101 (zero-extended to PAT_W), pattern register reset value
- CNT_W, 16, match counter width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  pattern write strobe, honoured only in IDLE
- cfg_pattern  in  PAT_W  new pattern value
- start  in  1  job start, sampled only in IDLE
- len  in  8  number of bytes in job, sampled with start
- abort  in  1  cancel current job
- in_valid  in  1  byte available
- in_data  in  8  byte, bit 7 serialized first
- in_ready  out  1  high only in LOAD
- busy  out  1  high in LOAD and SHIFT
- done  out  1  one-cycle pulse, job completed
- match  out  1  one-cycle pulse per pattern match
- match_cnt  out  CNT_W  matches in current/last job, saturating

## Operation
- Registers:
  - pattern: PAT_W bits.
  - hist: PAT_W-bit history shift register.
  - seen: saturating 0..PAT_W count of bits shifted this job.
  - remaining: 8 bits.
  - byte_sr: 8 bits.
  - bit_idx: 3 bits.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cfg_we=1 writes pattern.
  - start=1 clears hist, seen and match_cnt, and latches len into remaining.
  - If len!=0 → LOAD. If len==0 → DONE.
- LOAD:
  - in_ready=1.
  - On in_valid: capture in_data into byte_sr, set bit_idx=7 → SHIFT.
  - Without in_valid: stay in LOAD (stall, no timeout).
- SHIFT: each cycle does the following.
  - Shift: hist <= {hist[PAT_W-2:0], byte_sr[bit_idx]}. seen increments, saturating at PAT_W.
  - Match: the cycle matches when (seen+1)>=PAT_W and the next hist value equals pattern. On a match, next cycle match=1 and match_cnt increments, saturating at all-ones.
  - Byte end: after bit_idx==0, decrement remaining. Go to DONE if it was 1, else LOAD.
- DONE: done=1 for one cycle → IDLE.
- History persists across byte boundaries within a job. Matches overlap; there is no reset of hist after a match.
- abort in LOAD or SHIFT → IDLE next cycle. On abort:
  - No done pulse.
  - match_cnt keeps its value.
  - A match pending from the aborting cycle's bit is dropped.
  - abort in IDLE or DONE is ignored.
- Ignored inputs:
  - start outside IDLE.
  - cfg_we outside IDLE (pattern unchanged).
- match_cnt holds after the job ends until the next start or rst.

## Timing
- Reset values:
  - Outputs: in_ready=0, busy=0, done=0, match=0, match_cnt=0.
  - Internal: pattern=PAT_RST, state=IDLE, hist=0, seen=0.
- rst mid-job returns everything to reset values at the next edge; no done pulse.
- Job latency with start at cycle 0 and continuous in_valid:
  - LOAD at cycle 1.
  - SHIFT cycles 2–9 for byte 1.
  - Each further byte adds 9 cycles (1 LOAD + 8 SHIFT).
  - done at cycle 1+9·len.
- len==0: done at cycle 1, match_cnt=0.
- match and the match_cnt update are registered one cycle after the SHIFT cycle consuming the completing bit. A match on the final bit coincides with done.
- Throughput: 8 bits per 9 cycles. in_data is sampled only in the LOAD handshake cycle.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; pattern register reads back 0x55 via a scan of byte 0x55.
- start, len=1, in_data=0x55, in_valid held → in_ready high cycle 1 only; match and done both high at cycle 10; match_cnt=1.
- start, len=2, bytes 0x55, 0x55 → 5 match pulses (bits 8, 10, 12, 14, 16), each one cycle wide; done at cycle 19; match_cnt=5.
- cfg_we with 0xFF in IDLE, then stream 0xFF, 0x0F with len=2; a cfg_we 0x00 during the job is ignored → exactly 1 match; match_cnt=1.
- in_valid deasserted 3 cycles in LOAD → in_ready stays high, done delayed by 3. Separate job: abort in 4th SHIFT cycle → IDLE next cycle; busy=0, no done; match_cnt retained.
- Abort and reset cases:
  - start with len=0 → done at cycle 1, match_cnt=0.
  - rst asserted mid-SHIFT → next cycle all outputs at reset values, no done.
  - start while busy → ignored.
  - Saturation check with CNT_W=2 and 3 bytes of 0x55 → match_cnt=3, holding.
